// File: rtl/apb_master_nslv.sv
// APB3 master bridge: valid/ready command port in, one-cycle response pulse out,
// driving NUM_SLV APB slaves selected by the top SEL_W address bits.
// Adds wait-state support, slave error capture, decode errors and an access timeout.
module apb_master_nslv #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned NUM_SLV     = 2,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                        PCLK,
    input  logic                        RST_N,
    input  logic                        CMD_VALID,
    output logic                        CMD_READY,
    input  logic                        CMD_WRITE,
    input  logic [ADDR_W-1:0]           CMD_ADDR,
    input  logic [DATA_W-1:0]           CMD_WDATA,
    output logic                        RSP_VALID,
    output logic [DATA_W-1:0]           RSP_RDATA,
    output logic [1:0]                  RSP_CODE,
    output logic [ADDR_W-1:0]           PADDR,
    output logic                        PWRITE,
    output logic [DATA_W-1:0]           PWDATA,
    output logic [NUM_SLV-1:0]          PSEL,
    output logic                        PENABLE,
    input  logic [NUM_SLV*DATA_W-1:0]   PRDATA,
    input  logic [NUM_SLV-1:0]          PREADY,
    input  logic [NUM_SLV-1:0]          PSLVERR
);

    localparam int unsigned SEL_W = $clog2(NUM_SLV);
    // Counter only needs to reach TIMEOUT_CYC-1; keep at least one bit when disabled.
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [1:0] RSP_OKAY    = 2'b00;
    localparam logic [1:0] RSP_SLVERR  = 2'b01;
    localparam logic [1:0] RSP_DECERR  = 2'b10;
    localparam logic [1:0] RSP_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } state_t;

    // One-hot slave select for a given slave index.
    function automatic logic [NUM_SLV-1:0] sel_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_SLV-1:0] oh;
        oh = '0;
        for (int i = 0; i < int'(NUM_SLV); i++) begin
            oh[i] = (idx == SEL_W'(i));
        end
        return oh;
    endfunction

    state_t              state_q,     state_d;
    logic [SEL_W-1:0]    idx_q,       idx_d;
    logic [ADDR_W-1:0]   paddr_q,     paddr_d;
    logic                pwrite_q,    pwrite_d;
    logic [DATA_W-1:0]   pwdata_q,    pwdata_d;
    logic [NUM_SLV-1:0]  psel_q,      psel_d;
    logic                penable_q,   penable_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          rsp_code_q,  rsp_code_d;

    logic [SEL_W-1:0]    cmd_idx_s;
    logic                idx_valid_s;
    logic                pready_sel_s;
    logic                pslverr_sel_s;
    logic [DATA_W-1:0]   prdata_sel_s;
    logic                timeout_hit_s;

    assign cmd_idx_s     = CMD_ADDR[ADDR_W-1 -: SEL_W];
    assign idx_valid_s   = (32'(cmd_idx_s) < NUM_SLV);
    // A disabled timeout never matches because TIMEOUT_CYC-1 wraps past the counter range.
    assign timeout_hit_s = (TIMEOUT_CYC != 32'd0) && (32'(cnt_q) == (TIMEOUT_CYC - 32'd1));

    // Pick out only the addressed slave's ready, error and read data.
    always_comb begin
        pready_sel_s  = 1'b0;
        pslverr_sel_s = 1'b0;
        prdata_sel_s  = '0;
        for (int i = 0; i < int'(NUM_SLV); i++) begin
            pready_sel_s  = pready_sel_s  | (PREADY[i]  & (idx_q == SEL_W'(i)));
            pslverr_sel_s = pslverr_sel_s | (PSLVERR[i] & (idx_q == SEL_W'(i)));
            prdata_sel_s  = prdata_sel_s  |
                            (PRDATA[i*DATA_W +: DATA_W] & {DATA_W{idx_q == SEL_W'(i)}});
        end
    end

    // Next-state and next-output logic for the IDLE/SETUP/ACCESS sequencer.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        cmd_ready_d = cmd_ready_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_code_d  = rsp_code_q;

        case (state_q)
            ST_IDLE: begin
                psel_d      = '0;
                penable_d   = 1'b0;
                cmd_ready_d = 1'b1;
                if (CMD_VALID && cmd_ready_q) begin
                    idx_d    = cmd_idx_s;
                    paddr_d  = CMD_ADDR;
                    pwrite_d = CMD_WRITE;
                    pwdata_d = CMD_WDATA;
                    if (idx_valid_s) begin
                        state_d     = ST_SETUP;
                        psel_d      = sel_onehot(cmd_idx_s);
                        cmd_ready_d = 1'b0;
                        cnt_d       = '0;
                    end else begin
                        // No slave at this index: answer locally without touching the bus.
                        state_d     = ST_IDLE;
                        rsp_valid_d = 1'b1;
                        rsp_code_d  = RSP_DECERR;
                        rsp_rdata_d = '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ST_ACCESS: begin
                if (pready_sel_s) begin
                    state_d     = ST_IDLE;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    cmd_ready_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_code_d  = pslverr_sel_s ? RSP_SLVERR : RSP_OKAY;
                    rsp_rdata_d = (!pwrite_q && !pslverr_sel_s) ? prdata_sel_s : '0;
                end else if (timeout_hit_s) begin
                    state_d     = ST_IDLE;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    cmd_ready_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_code_d  = RSP_TIMEOUT;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                psel_d      = '0;
                penable_d   = 1'b0;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset drops the bus immediately and loses any transfer.
    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_code_q  <= RSP_OKAY;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            cmd_ready_q <= cmd_ready_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_code_q  <= rsp_code_d;
        end
    end

    assign CMD_READY = cmd_ready_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_CODE  = rsp_code_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;

endmodule

// File: doc/apb_master_nslv.md
Name: apb_master_nslv

Overview:
Parametrised APB3 master bridge. It generalises the fixed 2-slave, 9-bit address, 8-bit data APB top to configurable address/data width and N slaves. It adds PREADY wait states, PSLVERR capture, decode-error and timeout responses, and a valid/ready command port. It sits between a local command source (CPU/test sequencer) and NUM_SLV APB slaves.

Parameters:
ADDR_W, 9, PADDR width (>= SEL_W+1)
DATA_W, 8, PWDATA/PRDATA width
NUM_SLV, 2, number of slaves (2..16); SEL_W = $clog2(NUM_SLV)
TIMEOUT_CYC, 16, max ACCESS cycles before abort; 0 = timeout disabled

Ports:
PCLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
CMD_VALID  in  1  command request
CMD_READY  out  1  master can accept command
CMD_WRITE  in  1  1 = write, 0 = read
CMD_ADDR  in  ADDR_W  byte address; top SEL_W bits = slave index
CMD_WDATA  in  DATA_W  write data
RSP_VALID  out  1  one-cycle response pulse
RSP_RDATA  out  DATA_W  read data (0 on writes/errors)
RSP_CODE  out  2  00 OKAY, 01 SLVERR, 10 DECERR, 11 TIMEOUT
PADDR  out  ADDR_W  APB address
PWRITE  out  1  APB direction
PWDATA  out  DATA_W  APB write data
PSEL  out  NUM_SLV  one-hot slave select
PENABLE  out  1  APB enable
PRDATA  in  NUM_SLV*DATA_W  slave i read data at [i*DATA_W +: DATA_W]
PREADY  in  NUM_SLV  per-slave ready
PSLVERR  in  NUM_SLV  per-slave error

Behaviour:
- Reset (async assert, sync release): state IDLE; PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, RSP_VALID=0, RSP_RDATA=0, RSP_CODE=00, timeout counter=0. CMD_READY = (state==IDLE), so it reads 1 during reset.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: CMD_READY=1. A command is accepted on a rising edge with CMD_VALID&&CMD_READY. On accept, register idx=CMD_ADDR[ADDR_W-1 -: SEL_W], PADDR, PWRITE, and PWDATA (PWDATA loaded on reads too).
  - idx < NUM_SLV: next state SETUP.
  - idx >= NUM_SLV: stay IDLE, no PSEL. Next cycle RSP_VALID=1, RSP_CODE=10, RSP_RDATA=0.
- SETUP (exactly 1 cycle): PSEL[idx]=1, PENABLE=0, CMD_READY=0. Next state ACCESS; counter cleared.
- ACCESS: PSEL[idx]=1, PENABLE=1. Only PREADY[idx]/PSLVERR[idx]/PRDATA slice idx are observed; other slaves' inputs are ignored.
  - PREADY[idx]=1 at edge: go IDLE. Next cycle RSP_VALID=1 and RSP_CODE = PSLVERR[idx] ? 01 : 00. RSP_RDATA = PRDATA slice if read and no error, else 0.
  - PREADY[idx]=0: counter+1. If TIMEOUT_CYC!=0 and counter reaches TIMEOUT_CYC-1 with PREADY still low, abort: PSEL/PENABLE drop, go IDLE. Next cycle RSP_VALID=1, RSP_CODE=11, RSP_RDATA=0.
- Latency, zero wait states: accept edge at cycle 0 -> SETUP cycle 1 -> ACCESS cycle 2 -> RSP_VALID cycle 3. Each wait state adds 1 cycle.
- Back-to-back: a new command may be accepted in the same cycle RSP_VALID is high. Peak rate is one transfer per 3 cycles.
- RSP has no backpressure; the consumer must sample on the RSP_VALID pulse. RSP_RDATA/RSP_CODE hold their values until the next response.
- PADDR/PWRITE/PWDATA are stable from SETUP through the completing ACCESS cycle and hold their last value in IDLE. PENABLE is never high without PSEL.
- Reset mid-transfer: PSEL/PENABLE drop immediately (async), no response is generated, and the in-flight command is lost.

Test Plan:
1. NUM_SLV=2, zero-wait slaves. Write 0x0A5 data A5 to slave 0, then read 0x0A5. Required: PSEL=01 for 2 cycles, PENABLE high in cycle 2 only, read RSP_VALID at cycle 3 with RDATA=A5 and CODE=00. Repeat at 0x102 with data 5A and PSEL=10.
2. Slave 1 holds PREADY low for 3 ACCESS cycles on a read returning 3C. Required: PENABLE high 4 cycles, PADDR stable throughout, RSP at cycle 6 with RDATA=3C and CODE=00.
3. Slave 0 asserts PSLVERR with PREADY on a read. Required: RSP_CODE=01, RSP_RDATA=00.
4. TIMEOUT_CYC=4, slave never ready. Required: PSEL/PENABLE drop after 4 ACCESS cycles, then RSP_CODE=11; a following command completes normally.
5. NUM_SLV=3, ADDR_W=9, address 0x1C0 (idx=3). Required: no PSEL activity, RSP_VALID next cycle with CODE=10.
6. Assert RST_N low during ACCESS wait. Required: PSEL/PENABLE=0 asynchronously, no RSP_VALID, CMD_READY=1. After release, a write completes with latency 3.
